// File: rtl/obi_wb_pkg.sv
// obi_wb_pkg: shared types for the OBI to Wishbone bridge
package obi_wb_pkg;
  localparam int DATA_W = 32;
  localparam int SEL_W = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_t;
endpackage

// File: rtl/obi_wb_resp_stage.sv
// obi_wb_resp_stage: optional one-cycle register of the OBI response
module obi_wb_resp_stage
  import obi_wb_pkg::*;
#(
  parameter int RESP_REG = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t resp_i,
  output resp_t resp_o
);
  if (RESP_REG != 0) begin : g_reg
    resp_t resp_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) resp_q <= '0;
      else     resp_q <= resp_i;
    end
    assign resp_o = resp_q;
  end else begin : g_comb
    assign resp_o = resp_i;
  end
endmodule

// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: OBI core port to classic/pipelined Wishbone master bridge.
// Define OBI_WB_ERR_EN to let wb_err_i terminate transfers and drive err_o.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PIPELINED       = 1,
  parameter int RESP_REG        = 1
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_stall_i,
  input  logic                    wb_err_i,
  output logic                    proto_err_o
);
  localparam int MO = PIPELINED != 0 ? MAX_OUTSTANDING : 1;
  localparam int CW = $clog2(MO + 1);
`ifdef OBI_WB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [MO-1:0]           weq_q, weq_d;
  logic                    stb_q, stb_d, we_q, we_d, proto_q, proto_d;
  logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    term, pop, gnt;
  resp_t                   resp_d, resp;
  // weq_q holds the write flag of each outstanding transfer, oldest in bit 0
  always_comb begin
    term = wb_ack_i | (ERR_EN & wb_err_i);
    pop = term & (cnt_q != '0);
    gnt = !rst_core & req_i & (PIPELINED != 0 ? (!stb_q | !wb_stall_i) & (cnt_q < CW'(MO)) : state_q == IDLE);
    state_d = (state_q == IDLE && gnt) ? BUS :
              (state_q == BUS && pop) ? (RESP_REG != 0 ? RESP : IDLE) :
              (state_q == RESP) ? IDLE : state_q;
    stb_d = gnt | (stb_q & (PIPELINED != 0 ? wb_stall_i : !pop));
    we_d = gnt ? we_i : we_q;
    sel_d = gnt ? be_i : sel_q;
    adr_d = gnt ? addr_i : adr_q;
    dat_d = gnt ? wdata_i : dat_q;
    cnt_d = cnt_q + CW'(gnt) - CW'(pop);
    weq_d = pop ? weq_q >> 1 : weq_q;
    for (int i = 0; i < MO; i++)
      if (gnt && cnt_q - CW'(pop) == CW'(i)) weq_d[i] = we_i;
    proto_d = proto_q | (term & (cnt_q == '0)) | (!ERR_EN & wb_err_i & !wb_ack_i);
    resp_d.valid = pop;
    resp_d.err = pop & ERR_EN & wb_err_i;
    resp_d.rdata = (pop & !weq_q[0]) ? DATA_W'(wb_dat_i) : '0;
  end
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      weq_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      weq_q   <= weq_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      proto_q <= proto_d;
    end
  end
  obi_wb_resp_stage #(.RESP_REG(RESP_REG)) u_resp (
    .clk    (clk_core),
    .rst    (rst_core),
    .resp_i (resp_d),
    .resp_o (resp)
  );
  assign gnt_o       = gnt;
  assign rvalid_o    = resp.valid;
  assign rdata_o     = DATA_WIDTH'(resp.rdata);
  assign err_o       = resp.err;
  assign wb_cyc_o    = stb_q | (cnt_q != '0);
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign proto_err_o = proto_q;
endmodule
